// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Access-size and FSM state encodings plus byte-lane mask and extension constants.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int          LANE_W    = 8;
    localparam logic [3:0]  BYTE_MASK = 4'b0001;
    localparam logic [3:0]  HALF_MASK = 4'b0011;
    localparam logic [3:0]  WORD_MASK = 4'b1111;
    localparam logic [23:0] EXT_ZERO_B = 24'h000000;
    localparam logic [15:0] EXT_ZERO_H = 16'h0000;

    // The reserved encoding behaves exactly like a word access.
    function automatic size_e eff_size(input logic [1:0] raw);
        return (raw == SZ_RSVD) ? SZ_WORD : size_e'(raw);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering: store mask/data alignment and load extract/extend.
// Purely combinational; the offset arriving here is already the effective lane offset.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [31:0] rword_sh;

    assign shamt    = {offset, 3'b000};
    assign wdata_sh = wdata << shamt;
    assign rword_sh = rword >> shamt;

    always_comb begin
        byte_en   = WORD_MASK;
        rdata_ext = rword_sh;
        case (size)
            SZ_BYTE: begin
                byte_en   = BYTE_MASK << offset;
                rdata_ext = is_unsigned ? {EXT_ZERO_B, rword_sh[7:0]}
                                        : {{24{rword_sh[7]}}, rword_sh[7:0]};
            end
            SZ_HALF: begin
                byte_en   = HALF_MASK << offset;
                rdata_ext = is_unsigned ? {EXT_ZERO_H, rword_sh[15:0]}
                                        : {{16{rword_sh[15]}}, rword_sh[15:0]};
            end
            default: begin
                byte_en   = WORD_MASK;
                rdata_ext = rword_sh;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port data memory with a load/store FSM (IDLE -> WAIT -> RESP) and wait states.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses via rsp_err instead of aligning them.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    size_e         size_q, size_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH];

    logic          idle;
    logic          act_we, act_uns, act_mis, act_err;
    size_e         act_size;
    logic [AW-1:0] act_addr;
    logic [31:0]   act_wdata;
    logic [1:0]    act_off;
    logic [IDX_W-1:0] act_idx;
    logic          enter_resp, wr_en;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_sh, rdata_ext;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW];

    // In IDLE the live request drives the datapath so a zero-wait access can complete on its accept edge.
    assign idle      = (state_q == S_IDLE);
    assign act_we    = idle ? req_we                 : we_q;
    assign act_size  = idle ? eff_size(req_size)     : size_q;
    assign act_uns   = idle ? req_unsigned           : uns_q;
    assign act_addr  = idle ? req_addr[AW-1:0]       : addr_q;
    assign act_wdata = idle ? req_wdata              : wdata_q;
    assign act_idx   = act_addr[AW-1:2];

    assign act_mis = ((act_size == SZ_HALF) && act_addr[0]) ||
                     ((act_size == SZ_WORD) && (act_addr[1:0] != 2'b00));

    always_comb begin
        case (act_size)
            SZ_BYTE: act_off = act_addr[1:0];
            SZ_HALF: act_off = {act_addr[1], 1'b0};
            default: act_off = 2'b00;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign act_err = act_mis;
`else
    assign act_err = 1'b0;
`endif

    dmem_lane_unit u_lane (
        .size        (act_size),
        .is_unsigned (act_uns),
        .offset      (act_off),
        .wdata       (act_wdata),
        .rword       (mem_q[act_idx]),
        .byte_en     (byte_en),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    assign enter_resp = !reset &&
                        ((idle && req_valid && (WAIT_STATES == 0)) ||
                         ((state_q == S_WAIT) && (cnt_q == 3'd0)));
    assign wr_en      = enter_resp && act_we && !act_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = eff_size(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = (act_we || act_err) ? 32'h0 : rdata_ext;
            err_d   = act_err;
        end
    end

    // NOTE: state uses <= so every flop samples pre-edge values; blocking here would race the comb logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the memory array is deliberately not reset; reset must leave stored data intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[act_idx][LANE_W*b +: LANE_W] <= wdata_sh[LANE_W*b +: LANE_W];
            end
        end
    end

    assign req_ready = idle && !reset;
    assign rsp_valid = (state_q == S_RESP) && !reset;
    assign rsp_rdata = reset ? 32'h0 : rdata_q;
    assign rsp_err   = !reset && err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: four instances cover zero/three/two wait states and a 16-word wrap.
// Expectations for misaligned accesses follow DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_lsu;

    localparam int NI = 4;
    localparam int WS_T    [NI] = '{0, 3, 1, 2};
    localparam int DEPTH_T [NI] = '{256, 256, 16, 256};

    logic        clk;
    logic        reset        [NI];
    logic        req_valid    [NI];
    logic        req_ready    [NI];
    logic        req_we       [NI];
    logic [1:0]  req_size     [NI];
    logic        req_unsigned [NI];
    logic [31:0] req_addr     [NI];
    logic [31:0] req_wdata    [NI];
    logic        rsp_valid    [NI];
    logic [31:0] rsp_rdata    [NI];
    logic        rsp_err      [NI];

    int n_vec = 0;
    int n_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_lsu #(
            .DEPTH       (DEPTH_T[g]),
            .WAIT_STATES (WS_T[g])
        ) u_dut (
            .clk          (clk),
            .reset        (reset[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request/response; checks readiness and latency, returns the response fields.
    task automatic xact(input string tag, input int k, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
        int lat;
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_size[k] = sz;
        req_unsigned[k] = uns; req_addr[k] = addr; req_wdata[k] = wdata;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/rdy"}, 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid[k]) begin
                lat = c; rd = rsp_rdata[k]; er = rsp_err[k];
                break;
            end
        end
        check({tag, "/lat"}, 32'(lat), 32'(1 + WS_T[k]));
    endtask

    logic [31:0] rd;
    logic        er;
    logic        seen;
    logic [31:0] exp_rd;
    logic        exp_er;

    initial begin
        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_size[k] = 2'b00;
            req_unsigned[k] = 1'b0; req_addr[k] = 32'h0; req_wdata[k] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst%0d/ready", k), 32'(req_ready[k]), 32'd0);
            check($sformatf("rst%0d/valid", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("rst%0d/rdata", k), rsp_rdata[k], 32'h0);
            check($sformatf("rst%0d/err", k), 32'(rsp_err[k]), 32'd0);
            reset[k] = 1'b0;
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) check($sformatf("rst%0d/ready_after", k), 32'(req_ready[k]), 32'd1);

        // Word store/load, zero wait states.
        xact("sw10", 0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
        check("sw10/rdata", rd, 32'h0);
        check("sw10/err", 32'(er), 32'd0);
        xact("lw10", 0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
        check("lw10/rdata", rd, 32'hDEADBEEF);
        check("lw10/err", 32'(er), 32'd0);

        // Byte store into a cleared word, then signed/unsigned/word loads.
        xact("sw20", 0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
        xact("sb22", 0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h12345680, rd, er);
        xact("lb22", 0, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, rd, er);
        check("lb22/rdata", rd, 32'hFFFFFF80);
        xact("lbu22", 0, 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, rd, er);
        check("lbu22/rdata", rd, 32'h00000080);
        xact("lw20", 0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er);
        check("lw20/rdata", rd, 32'h00800000);

        // Upper half-word store, half loads, reserved size acting as word.
        xact("sw24", 0, 1'b1, 2'b10, 1'b0, 32'h24, 32'h0, rd, er);
        xact("sh26", 0, 1'b1, 2'b01, 1'b0, 32'h26, 32'hCAFEBEEF, rd, er);
        xact("lh26", 0, 1'b0, 2'b01, 1'b0, 32'h26, 32'h0, rd, er);
        check("lh26/rdata", rd, 32'hFFFFBEEF);
        xact("lhu26", 0, 1'b0, 2'b01, 1'b1, 32'h26, 32'h0, rd, er);
        check("lhu26/rdata", rd, 32'h0000BEEF);
        xact("lrsv24", 0, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0, rd, er);
        check("lrsv24/rdata", rd, 32'hBEEF0000);

        // Misaligned half store, then the surrounding word.
        xact("sw30", 0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_er = 1'b1; exp_rd = 32'h00000000;
`else
        exp_er = 1'b0; exp_rd = 32'h0000BEEF;
`endif
        xact("sh31", 0, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF, rd, er);
        check("sh31/err", 32'(er), 32'(exp_er));
        xact("lw30", 0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er);
        check("lw30/rdata", rd, exp_rd);
        check("lw30/err", 32'(er), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_rd = 32'h00000000;
`else
        exp_rd = 32'h00000080;
`endif
        xact("lh23", 0, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd, er);
        check("lh23/rdata", rd, exp_rd);
        check("lh23/err", 32'(er), 32'(exp_er));

        // Address wrap on a 16-word memory.
        xact("sw40", 2, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, rd, er);
        xact("lw00", 2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, er);
        check("lw00/rdata", rd, 32'h12345678);

        // Ready/valid timing with three wait states; request held while busy.
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h0;
        check("ws3/ready_T", 32'(req_ready[1]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("ws3/ready_T%0d", i), 32'(req_ready[1]), 32'd0);
            check($sformatf("ws3/valid_T%0d", i), 32'(rsp_valid[1]), 32'(i == 4));
            if (i == 4) req_valid[1] = 1'b0;
        end
        @(negedge clk);
        check("ws3/ready_T5", 32'(req_ready[1]), 32'd1);
        check("ws3/valid_T5", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        check("ws3/ready_T6", 32'(req_ready[1]), 32'd1);

        // Reset one cycle after accepting a store drops it.
        xact("sw08", 3, 1'b1, 2'b10, 1'b0, 32'h8, 32'h11111111, rd, er);
        @(negedge clk);
        req_valid[3] = 1'b1; req_we[3] = 1'b1; req_size[3] = 2'b10;
        req_addr[3] = 32'h8; req_wdata[3] = 32'hAAAAAAAA;
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        @(negedge clk);
        reset[3] = 1'b1;
        @(negedge clk);
        check("rstmid/ready", 32'(req_ready[3]), 32'd0);
        seen = rsp_valid[3];
        reset[3] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid[3];
        end
        check("rstmid/no_rsp", 32'(seen), 32'd0);
        xact("lw08", 3, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er);
        check("lw08/rdata", rd, 32'h11111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
